// File: rtl/risc_v_mike_pkg.sv
// Shared types and constants for the risc_v_mike UART transmit path.
package risc_v_mike_pkg;

   localparam int unsigned UART_DATA_WIDTH     = 8;
   localparam int unsigned TX_SCHED_FIFO_DEPTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SEND  = 2'd2,
      ST_CLEAR = 2'd3
   } t_tx_sched_state;

endpackage

// File: rtl/risc_v_mike_sync_fifo.sv
// Single-clock FIFO with registered full/empty/level and a look-ahead head output.
module risc_v_mike_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wr_data,
   output logic [WIDTH-1:0]       head_c,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;
   logic [LVL_W-1:0] level_next;

   // A push into a full queue is dropped even when a pop happens in the same cycle.
   assign push_ok    = push && !full;
   assign pop_ok     = pop && !empty;
   assign level_next = level + LVL_W'(push_ok) - LVL_W'(pop_ok);
   assign head_c     = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
         level <= level_next;
         full  <= (level_next == LVL_W'(DEPTH));
         empty <= (level_next == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/risc_v_mike_uart_tx_sched.sv
// Transmit scheduler: queues CPU bytes and hands them to the UART one at a time.
// Optional per-byte watchdog enabled by defining RISC_V_MIKE_TX_SCHED_TIMEOUT_EN.
module risc_v_mike_uart_tx_sched
   import risc_v_mike_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = TX_SCHED_FIFO_DEPTH,
   parameter int unsigned TX_TIMEOUT = 65536
) (
   input  logic                        clk,
   input  logic                        n_rst,
   input  logic                        wr_en,
   input  logic [UART_DATA_WIDTH-1:0]  wr_data,
   input  logic                        ovf_clr,
   input  logic                        uart_tx_flag,
   output logic [UART_DATA_WIDTH-1:0]  uart_tx_data,
   output logic                        uart_tx_send,
   output logic                        uart_tx_flag_clr,
   output logic                        fifo_full,
   output logic                        fifo_empty,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        busy,
   output logic                        overflow,
   output logic                        tx_timeout
);

   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (TX_TIMEOUT < 2)) begin : g_param_check
      $error("risc_v_mike_uart_tx_sched: FIFO_DEPTH must be a power of 2 >= 2, TX_TIMEOUT >= 2");
   end

   t_tx_sched_state            state;
   logic [UART_DATA_WIDTH-1:0] head_c;
   logic                       pop_c;
   logic                       expire_c;

   assign pop_c = (state == ST_IDLE) && !fifo_empty;

`ifdef RISC_V_MIKE_TX_SCHED_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TX_TIMEOUT + 1);
   logic [CNT_W-1:0] cnt;

   assign expire_c = ((state == ST_SEND) || (state == ST_CLEAR)) &&
                     (cnt == CNT_W'(TX_TIMEOUT - 1));

   // Watchdog counts every cycle spent waiting on the UART for the current byte.
   always_ff @(posedge clk) begin
      if (!n_rst)                                          cnt <= '0;
      else if (state == ST_LOAD)                           cnt <= '0;
      else if ((state == ST_SEND) || (state == ST_CLEAR))  cnt <= cnt + CNT_W'(1);
   end
`else
   assign expire_c = 1'b0;
`endif

   risc_v_mike_sync_fifo #(
      .WIDTH (UART_DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .n_rst   (n_rst),
      .push    (wr_en),
      .pop     (pop_c),
      .wr_data (wr_data),
      .head_c  (head_c),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   // Handshake FSM; sticky flags give priority to a new event over ovf_clr.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state            <= ST_IDLE;
         uart_tx_data     <= '0;
         uart_tx_send     <= 1'b0;
         uart_tx_flag_clr <= 1'b0;
         busy             <= 1'b0;
         overflow         <= 1'b0;
         tx_timeout       <= 1'b0;
      end else begin
         if (wr_en && fifo_full) overflow <= 1'b1;
         else if (ovf_clr)       overflow <= 1'b0;

         if (expire_c)     tx_timeout <= 1'b1;
         else if (ovf_clr) tx_timeout <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (pop_c) begin
                  uart_tx_data <= head_c;
                  busy         <= 1'b1;
                  state        <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               uart_tx_send <= 1'b1;
               state        <= ST_SEND;
            end
            ST_SEND: begin
               if (expire_c) begin
                  uart_tx_send <= 1'b0;
                  busy         <= 1'b0;
                  state        <= ST_IDLE;
               end else if (uart_tx_flag) begin
                  uart_tx_send     <= 1'b0;
                  uart_tx_flag_clr <= 1'b1;
                  state            <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               if (expire_c || !uart_tx_flag) begin
                  uart_tx_flag_clr <= 1'b0;
                  busy             <= 1'b0;
                  state            <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
